// File: rtl/egg_timer_pkg.sv
// rtl/egg_timer_pkg.sv - shared BCD types, limits, mode encoding and set-value sanitizers
package egg_timer_pkg;

    typedef logic [7:0] bcd_pair_t;

    localparam bcd_pair_t SEC_MAX_BCD = 8'h59;
    localparam bcd_pair_t MIN_MAX_BCD = 8'h99;

    typedef enum logic [2:0] {
        MODE_IDLE,
        MODE_SET_SEC,
        MODE_SET_MIN,
        MODE_COUNT,
        MODE_PAUSE,
        MODE_ALARM
    } mode_t;

    // Out-of-range switch settings snap to the largest legal value rather than wrapping.
    function automatic bcd_pair_t sanitize_sec(input bcd_pair_t v);
        return (v[7:4] > 4'd5 || v[3:0] > 4'd9) ? SEC_MAX_BCD : v;
    endfunction

    function automatic bcd_pair_t sanitize_min(input bcd_pair_t v);
        return (v[7:4] > 4'd9 || v[3:0] > 4'd9) ? MIN_MAX_BCD : v;
    endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// rtl/countdown_sequencer_if.sv - mode inputs, set value and display/status outputs of the sequencer
interface countdown_sequencer_if;
    import egg_timer_pkg::*;

    logic      tick_1hz;
    logic      clear;
    logic      load_sec;
    logic      load_min;
    logic      run;
    logic      flash;
    bcd_pair_t val_bcd;
    bcd_pair_t min_bcd;
    bcd_pair_t sec_bcd;
    logic      is_zero;
    logic      done_pulse;
    logic      blank;
    logic      alarm_expired;

    modport master (
        output tick_1hz, clear, load_sec, load_min, run, flash, val_bcd,
        input  min_bcd, sec_bcd, is_zero, done_pulse, blank, alarm_expired
    );

    modport slave (
        input  tick_1hz, clear, load_sec, load_min, run, flash, val_bcd,
        output min_bcd, sec_bcd, is_zero, done_pulse, blank, alarm_expired
    );

endinterface

// File: rtl/bcd_mmss_decrement.sv
// rtl/bcd_mmss_decrement.sv - one-second BCD decrement of MM:SS, saturating at 00:00
module bcd_mmss_decrement (
    input  logic [15:0] mmss,
    output logic [15:0] mmssNext,
    output logic        reachesZero
);
    logic [3:0] minTens, minUnits, secTens, secUnits;

    always_comb begin
        minTens  = mmss[15:12];
        minUnits = mmss[11:8];
        secTens  = mmss[7:4];
        secUnits = mmss[3:0];

        if (mmss == 16'h0000) begin
            // hold rather than wrap to 99:59
        end else if (mmss[7:0] != 8'h00) begin
            if (secUnits != 4'd0) begin
                secUnits = secUnits - 4'd1;
            end else begin
                secUnits = 4'd9;
                secTens  = secTens - 4'd1;
            end
        end else begin
            secTens  = 4'd5;
            secUnits = 4'd9;
            if (minUnits != 4'd0) begin
                minUnits = minUnits - 4'd1;
            end else begin
                minUnits = 4'd9;
                minTens  = minTens - 4'd1;
            end
        end

        mmssNext    = {minTens, minUnits, secTens, secUnits};
        reachesZero = (mmss != 16'h0000) && (mmssNext == 16'h0000);
    end

endmodule

// File: rtl/countdown_sequencer.sv
// rtl/countdown_sequencer.sv - egg timer MM:SS countdown register with load, pause and alarm flash
module countdown_sequencer #(
    parameter int ALARM_TICKS = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_sequencer_if.slave  bus
);
    import egg_timer_pkg::*;

    localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);

    mode_t      modeQ, modeNext;
    bcd_pair_t  minQ, secQ;
    logic       donePulseQ, blankQ;
    logic [7:0] alarmCnt;
    logic [15:0] decValue;
    logic        decReachesZero;
    logic        isZero;

    bcd_mmss_decrement u_decrement (
        .mmss        ({minQ, secQ}),
        .mmssNext    (decValue),
        .reachesZero (decReachesZero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) modeQ <= MODE_IDLE;
        else       modeQ <= modeNext;
    end

    // The datapath acts on the decoded mode of this cycle so loads and the
    // first tick of a run take effect at the very next edge.
    always_comb begin
        modeNext = MODE_PAUSE;
        if      (bus.clear)    modeNext = MODE_IDLE;
        else if (bus.load_sec) modeNext = MODE_SET_SEC;
        else if (bus.load_min) modeNext = MODE_SET_MIN;
        else if (bus.run)      modeNext = MODE_COUNT;
        else if (bus.flash)    modeNext = MODE_ALARM;
    end

    assign isZero = (minQ == 8'h00) && (secQ == 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            minQ       <= 8'h00;
            secQ       <= 8'h00;
            donePulseQ <= 1'b0;
            blankQ     <= 1'b0;
            alarmCnt   <= 8'd0;
        end else begin
            donePulseQ <= 1'b0;
            if (modeNext != MODE_ALARM) begin
                blankQ   <= 1'b0;
                alarmCnt <= 8'd0;
            end
            case (modeNext)
                MODE_IDLE: begin
                    minQ <= 8'h00;
                    secQ <= 8'h00;
                end
                MODE_SET_SEC: secQ <= sanitize_sec(bus.val_bcd);
                MODE_SET_MIN: minQ <= sanitize_min(bus.val_bcd);
                MODE_COUNT: begin
                    if (bus.tick_1hz && !isZero) begin
                        {minQ, secQ} <= decValue;
                        donePulseQ   <= decReachesZero;
                    end
                end
                MODE_ALARM: begin
                    if (bus.tick_1hz) begin
                        blankQ <= ~blankQ;
                        if (alarmCnt < ALARM_LIMIT) alarmCnt <= alarmCnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.min_bcd       = minQ;
    assign bus.sec_bcd       = secQ;
    assign bus.is_zero       = isZero;
    assign bus.done_pulse    = donePulseQ;
    assign bus.blank         = blankQ;
    assign bus.alarm_expired = (modeQ == MODE_ALARM) && (alarmCnt >= ALARM_LIMIT);

endmodule

// File: tb/tb_countdown_sequencer.sv
// tb/tb_countdown_sequencer.sv - directed vector table plus countdown, pause, alarm and reset sequences
module tb_countdown_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    countdown_sequencer_if bus ();

    countdown_sequencer #(.ALARM_TICKS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       c, ls, lm, r, f, t;
        logic [7:0] val;
        logic [7:0] eMin, eSec;
        logic       eZero, eDone;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic c, logic ls, logic lm, logic r, logic f, logic t,
                                 logic [7:0] val, logic [7:0] eMin, logic [7:0] eSec,
                                 logic eZero, logic eDone);
        vec_t v;
        v.c = c; v.ls = ls; v.lm = lm; v.r = r; v.f = f; v.t = t;
        v.val = val; v.eMin = eMin; v.eSec = eSec; v.eZero = eZero; v.eDone = eDone;
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic c, logic ls, logic lm, logic r, logic f, logic t, logic [7:0] val);
        bus.clear = c; bus.load_sec = ls; bus.load_min = lm;
        bus.run = r; bus.flash = f; bus.tick_1hz = t; bus.val_bcd = val;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int doneCount;
    int remain;
    logic [15:0] expMmss;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        step();
        step();
        chk("rst_min", bus.min_bcd, 8'h00);
        chk("rst_sec", bus.sec_bcd, 8'h00);
        chk("rst_zero", bus.is_zero, 1);
        chk("rst_done", bus.done_pulse, 0);
        chk("rst_blank", bus.blank, 0);
        chk("rst_expired", bus.alarm_expired, 0);
        #2 reset = 1'b0;

        //                c  ls lm r  f  t  val    min    sec   zero done
        vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 8'h05, 8'h00, 8'h05, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 8'h7A, 8'h00, 8'h59, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 8'hA3, 8'h99, 8'h59, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 8'h12, 8'h12, 8'h59, 0, 0));
        vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 8'h30, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 8'h30, 8'h00, 8'h30, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 8'h01, 8'h01, 8'h30, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 8'h00, 8'h01, 8'h29, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 8'h00, 8'h01, 8'h29, 0, 0));
        vecs.push_back(mkv(1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 1, 0, 1, 8'h10, 8'h00, 8'h10, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h09, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h08, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 8'h10, 8'h10, 8'h00, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 8'h00, 8'h09, 8'h59, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 8'h01, 8'h09, 8'h01, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 1, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 8'h23, 8'h00, 8'h23, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 1, 0, 1, 8'h02, 8'h02, 8'h23, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 1, 8'h00, 8'h02, 8'h22, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].c, vecs[i].ls, vecs[i].lm, vecs[i].r, vecs[i].f, vecs[i].t, vecs[i].val);
            step();
            chk($sformatf("vec%0d_min", i), bus.min_bcd, vecs[i].eMin);
            chk($sformatf("vec%0d_sec", i), bus.sec_bcd, vecs[i].eSec);
            chk($sformatf("vec%0d_zero", i), bus.is_zero, vecs[i].eZero);
            chk($sformatf("vec%0d_done", i), bus.done_pulse, vecs[i].eDone);
            chk($sformatf("vec%0d_blank", i), bus.blank, 0);
        end

        // 01:05 countdown over 66 ticks, each followed by an idle run cycle
        drive(1, 0, 0, 0, 0, 0, 8'h00); step();
        drive(0, 1, 0, 0, 0, 0, 8'h05); step();
        drive(0, 0, 1, 0, 0, 0, 8'h01); step();
        chk("cd_start", {bus.min_bcd, bus.sec_bcd}, 16'h0105);
        for (int k = 1; k <= 66; k++) begin
            drive(0, 0, 0, 1, 0, 1, 8'h00); step();
            remain = (65 - k) < 0 ? 0 : 65 - k;
            expMmss = to_bcd(remain);
            chk($sformatf("cd%0d_mmss", k), {bus.min_bcd, bus.sec_bcd}, expMmss);
            chk($sformatf("cd%0d_done", k), bus.done_pulse, (k == 65));
            chk($sformatf("cd%0d_zero", k), bus.is_zero, (k >= 65));
            drive(0, 0, 0, 1, 0, 0, 8'h00); step();
            chk($sformatf("cd%0d_gapdone", k), bus.done_pulse, 0);
        end

        // pause: 00:10 -> 3 ticks -> hold 5 ticks -> 7 more ticks
        drive(1, 0, 0, 0, 0, 0, 8'h00); step();
        drive(0, 1, 0, 0, 0, 0, 8'h10); step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 1, 8'h00); step();
            drive(0, 0, 0, 1, 0, 0, 8'h00); step();
        end
        chk("pause_run3", {bus.min_bcd, bus.sec_bcd}, 16'h0007);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 1, 8'h00); step();
            chk($sformatf("pause_hold%0d", k), {bus.min_bcd, bus.sec_bcd}, 16'h0007);
            drive(0, 0, 0, 0, 0, 0, 8'h00); step();
        end
        doneCount = 0;
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, 0, 1, 0, 1, 8'h00); step();
            if (bus.done_pulse === 1'b1) doneCount++;
            drive(0, 0, 0, 1, 0, 0, 8'h00); step();
            if (bus.done_pulse === 1'b1) doneCount++;
        end
        chk("pause_final", {bus.min_bcd, bus.sec_bcd}, 16'h0000);
        chk("pause_donecount", doneCount, 1);

        // alarm with ALARM_TICKS=4, value 00:03 held throughout
        drive(0, 1, 0, 0, 0, 0, 8'h03); step();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 0, 1, 1, 8'h00); step();
            chk($sformatf("al%0d_blank", k), bus.blank, (k % 2 == 1));
            chk($sformatf("al%0d_expired", k), bus.alarm_expired, (k >= 4));
            chk($sformatf("al%0d_sec", k), bus.sec_bcd, 8'h03);
            drive(0, 0, 0, 0, 1, 0, 8'h00); step();
            chk($sformatf("al%0d_gapblank", k), bus.blank, (k % 2 == 1));
        end
        drive(0, 0, 0, 0, 1, 1, 8'h00); step();
        chk("al5_blank", bus.blank, 1);
        chk("al5_expired", bus.alarm_expired, 1);
        drive(0, 0, 0, 0, 0, 0, 8'h00); step();
        chk("al_drop_blank", bus.blank, 0);
        chk("al_drop_expired", bus.alarm_expired, 0);
        drive(0, 0, 0, 0, 1, 0, 8'h00); step();
        chk("al_reenter_expired", bus.alarm_expired, 0);

        // asynchronous reset at 00:42 in COUNT
        drive(0, 1, 0, 0, 0, 0, 8'h42); step();
        drive(0, 0, 0, 1, 0, 0, 8'h00); step();
        chk("ar_pre", {bus.min_bcd, bus.sec_bcd}, 16'h0042);
        #2 reset = 1'b1;
        #1;
        chk("ar_mmss", {bus.min_bcd, bus.sec_bcd}, 16'h0000);
        chk("ar_zero", bus.is_zero, 1);
        bus.tick_1hz = 1'b1;
        step();
        #2 reset = 1'b0;
        bus.tick_1hz = 1'b0;
        step();
        chk("ar_after", {bus.min_bcd, bus.sec_bcd}, 16'h0000);
        chk("ar_after_done", bus.done_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Controller for the egg timer's time-keeping datapath. It holds the MM:SS countdown value in BCD, loads it from the set inputs, and decrements it on the 1 Hz tick while running. It reports zero back to the mode FSM and drives display blanking while the alarm flashes. It sits between the mode FSM's one-hot outputs and the seven-segment display driver.

## Interface
- ALARM_TICKS, default 30: number of 1 Hz ticks in flash mode before `alarm_expired` asserts (1..255).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- tick_1hz  in  1  single-cycle pulse, once per second, synchronous to clk.
- clear  in  1  mode FSM init state; level.
- load_sec  in  1  mode FSM seconds-set state; level.
- load_min  in  1  mode FSM minutes-set state; level.
- run  in  1  mode FSM counting state; level.
- flash  in  1  mode FSM done/flashing state; level.
- val_bcd  in  8  set value in BCD from the switches, [7:4] tens, [3:0] units.
- min_bcd  out  8  minutes, BCD 00..99.
- sec_bcd  out  8  seconds, BCD 00..59.
- is_zero  out  1  high when min_bcd==00 and sec_bcd==00.
- done_pulse  out  1  one-cycle pulse when a run decrement reaches 00:00.
- blank  out  1  display blank request.
- alarm_expired  out  1  high once ALARM_TICKS ticks have elapsed in flash mode.

## Operation
- Mode register values: IDLE, SET_SEC, SET_MIN, COUNT, PAUSE, ALARM. The register is updated every cycle from the inputs.
- Input priority: clear > load_sec > load_min > run > flash. With no mode input asserted the mode is PAUSE, or IDLE directly after reset.
- IDLE (clear): min and sec are forced to 00. blank=0. Alarm counter=0.
- SET_SEC: sec_bcd <= sanitize_sec(val_bcd) every cycle. If tens>5 or units>9, the loaded value is 59.
- SET_MIN: min_bcd <= sanitize_min(val_bcd) every cycle. If either nibble>9, the loaded value is 99.
- COUNT: on tick_1hz with !is_zero, MM:SS is decremented in BCD.
  - Units borrow: units 0 becomes 9 and tens decrements.
  - Seconds 00 becomes 59 and minutes decrements.
  - At 00:00 the value holds. It never wraps.
- PAUSE: value held. Ticks ignored.
- ALARM (flash): value held. blank toggles on each tick_1hz. The saturating alarm counter increments on each tick. alarm_expired=1 when counter ≥ ALARM_TICKS.
- Leaving ALARM forces blank=0 and counter=0 in the same cycle. blank is 0 in every mode except ALARM.
- done_pulse is registered. It is high exactly the cycle after the tick whose decrement produced 00:00, and only from COUNT. Loading or clearing to 00:00 produces no pulse.
- is_zero is derived combinationally from the output registers, so it is effectively registered.

## Timing
- Reset values: min_bcd=00, sec_bcd=00, is_zero=1, done_pulse=0, blank=0, alarm_expired=0, mode=IDLE.
- Reset mid-count is asynchronous and immediate. There is no pending decrement after release.
- Load latency: 1 cycle from val_bcd to the output register.
- Decrement latency: 1 cycle after the tick_1hz cycle.
- A tick in the same cycle run first rises is honoured (decrements).
- A tick in the same cycle as clear or load is ignored; clear or load wins.
- A tick on the cycle the value is already 00:00 in COUNT produces no change and no pulse.
- alarm_expired asserts the cycle after the ALARM_TICKS-th tick and stays high while flash is held.

## Structure
- Shared package egg_timer_pkg holds:
  - the BCD digit pair type (8-bit);
  - constants SEC_MAX_BCD=8'h59 and MIN_MAX_BCD=8'h99;
  - the mode enumeration.
- One combinational sub-module, bcd_mmss_decrement: 16-bit MM:SS in, 16-bit out, plus a reaches_zero flag. It saturates at 00:00.
- Sanitize functions live in the package.

## Test plan
- Load and countdown:
  - load_sec with val 8'h05, then load_min with 8'h01, then run with 66 ticks.
  - Required: sequence 01:05 → 01:00 → 00:59 … → 00:00.
  - done_pulse high exactly once, on the cycle after tick 65. is_zero high from then on.
- Sanitize: load_sec val 8'h7A gives sec 59. load_min val 8'hA3 gives min 99.
- Priority and tick collisions:
  - clear and load_sec asserted together with val 8'h30: result is 00:00.
  - Tick coincident with clear: no decrement.
- Pause:
  - From 00:10, run for 3 ticks gives 00:07.
  - All mode inputs low for 5 ticks: value stays 00:07.
  - run again for 7 ticks: reaches 00:00 with one done_pulse.
- Alarm (ALARM_TICKS=4):
  - flash held for 4 ticks: blank toggles 1,0,1,0 and alarm_expired rises after tick 4.
  - Drop flash: blank=0 and alarm_expired=0 the next cycle.
- Reset mid-count: assert reset asynchronously at 00:42 in COUNT. Outputs read 00:00, is_zero=1, with no clock edge required.
